// File: rtl/reg_bank_pkg.sv
// Shared defaults and constants for the scoreboarded register bank.
package reg_bank_pkg;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_W_DEF;
  localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/reg_bank_sb_if.sv
// Issue/return bus between decode logic, memory return path and the register bank.
interface reg_bank_sb_if #(
  parameter int unsigned DATA_W = reg_bank_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = reg_bank_pkg::ADDR_W_DEF
) ();
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] doutA;
  logic [DATA_W-1:0] doutB;
  logic              rdyA;
  logic              rdyB;
  logic [ADDR_W-1:0] Rw;
  logic              WE_Reg;
  logic [DATA_W-1:0] dIN;
  logic              wr_ack;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_issue_ack;
  logic              ld_ret;
  logic [ADDR_W-1:0] ld_ret_rd;
  logic [DATA_W-1:0] ld_ret_data;
  logic [ADDR_W:0]   busy_cnt;
  logic              err;

  modport master (
    output Ra, Rb, Rw, WE_Reg, dIN, ld_issue, ld_rd, ld_ret, ld_ret_rd, ld_ret_data,
    input  doutA, doutB, rdyA, rdyB, wr_ack, ld_issue_ack, busy_cnt, err
  );

  modport slave (
    input  Ra, Rb, Rw, WE_Reg, dIN, ld_issue, ld_rd, ld_ret, ld_ret_rd, ld_ret_data,
    output doutA, doutB, rdyA, rdyB, wr_ack, ld_issue_ack, busy_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding-load count, sticky error, acks.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WE_Reg,
  input  logic [ADDR_W-1:0]      Rw,
  input  logic                   ld_issue,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic                   ld_ret,
  input  logic [ADDR_W-1:0]      ld_ret_rd,
  output logic                   wr_ack,
  output logic                   ld_issue_ack,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt,
  output logic                   err
);
  logic                   rw_nz, rd_nz, ret_nz, clr, inc, stray_ret;
  logic [(2**ADDR_W)-1:0] busy_nxt;

  always_comb begin
    rw_nz        = (Rw != ADDR_W'(REG_ZERO));
    rd_nz        = (ld_rd != ADDR_W'(REG_ZERO));
    ret_nz       = (ld_ret_rd != ADDR_W'(REG_ZERO));
    clr          = ld_ret & busy[ld_ret_rd] & ret_nz;
    stray_ret    = ld_ret & ret_nz & ~busy[ld_ret_rd];
    wr_ack       = WE_Reg & (~rw_nz | ~busy[Rw]);
    ld_issue_ack = ld_issue & (~rd_nz | ~busy[ld_rd] | (clr & (ld_ret_rd == ld_rd)));
    inc          = ld_issue_ack & rd_nz;
    // Return clears first so a same-cycle issue to that register leaves it busy.
    busy_nxt = busy;
    if (ld_ret) busy_nxt[ld_ret_rd] = 1'b0;
    if (inc)    busy_nxt[ld_rd]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(clr);
      if (stray_ret) err <= 1'b1;
    end
  end
endmodule

// File: rtl/reg_bank_sb.sv
// Two-read register bank with ALU and load-return write ports, same-cycle bypass
// and load scoreboard; register 0 is hard-wired to zero.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_sb_if.slave bus
);
  logic [DATA_W-1:0]      mem [2**ADDR_W];
  logic [(2**ADDR_W)-1:0] busy;
  logic                   wr_ack, ld_issue_ack, err;
  logic [ADDR_W:0]        busy_cnt;
  logic [DATA_W:0]        port_a, port_b;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .WE_Reg       (bus.WE_Reg),
    .Rw           (bus.Rw),
    .ld_issue     (bus.ld_issue),
    .ld_rd        (bus.ld_rd),
    .ld_ret       (bus.ld_ret),
    .ld_ret_rd    (bus.ld_ret_rd),
    .wr_ack       (wr_ack),
    .ld_issue_ack (ld_issue_ack),
    .busy         (busy),
    .busy_cnt     (busy_cnt),
    .err          (err)
  );

  // Load return is applied after the ALU write so it wins on a shared register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      if (wr_ack && bus.Rw != ADDR_W'(REG_ZERO)) mem[bus.Rw] <= bus.dIN;
      if (bus.ld_ret && bus.ld_ret_rd != ADDR_W'(REG_ZERO)) mem[bus.ld_ret_rd] <= bus.ld_ret_data;
    end
  end

  // Returns {rdy, data} for one read address.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    if (!rst_n || a == ADDR_W'(REG_ZERO)) return {1'b1, {DATA_W{1'b0}}};
    if (bus.ld_ret && bus.ld_ret_rd == a) return {1'b1, bus.ld_ret_data};
    if (wr_ack && bus.Rw == a)            return {1'b1, bus.dIN};
    return {~busy[a], mem[a]};
  endfunction

  always_comb begin
    port_a = read_port(bus.Ra);
    port_b = read_port(bus.Rb);
  end

  assign bus.doutA        = port_a[DATA_W-1:0];
  assign bus.rdyA         = port_a[DATA_W];
  assign bus.doutB        = port_b[DATA_W-1:0];
  assign bus.rdyB         = port_b[DATA_W];
  assign bus.wr_ack       = wr_ack;
  assign bus.ld_issue_ack = ld_issue_ack;
  assign bus.busy_cnt     = busy_cnt;
  assign bus.err          = err;
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed self-checking bench for reg_bank_sb.
module tb_reg_bank_sb;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_bank_sb_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  reg_bank_sb #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.Ra = '0; bus.Rb = '0; bus.Rw = '0; bus.WE_Reg = 1'b0; bus.dIN = '0;
    bus.ld_issue = 1'b0; bus.ld_rd = '0; bus.ld_ret = 1'b0; bus.ld_ret_rd = '0;
    bus.ld_ret_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.WE_Reg = 1'b1; bus.Rw = 5'd9; bus.dIN = 64'd15; bus.Ra = 5'd9;
    #1;
    total++; if (bus.doutA !== 64'd0) begin bad++; $display("FAIL rst_doutA got=%0h exp=0", bus.doutA); end
    total++; if (bus.rdyA !== 1'b1 || bus.rdyB !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b%b exp=11", bus.rdyA, bus.rdyB); end
    total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_busy_cnt got=%0d exp=0", bus.busy_cnt); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_alu_write();
    bus.WE_Reg = 1'b1; bus.Rw = 5'd9; bus.dIN = 64'd15; bus.Ra = 5'd9; bus.Rb = 5'd0;
    #1;
    total++; if (bus.wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", bus.wr_ack); end
    total++; if (bus.doutA !== 64'd15 || bus.rdyA !== 1'b1) begin bad++; $display("FAIL wr_bypass got=%0d/%b exp=15/1", bus.doutA, bus.rdyA); end
    total++; if (bus.doutB !== 64'd0) begin bad++; $display("FAIL wr_doutB got=%0h exp=0", bus.doutB); end
    step();
    bus.Ra = 5'd9;
    #1;
    total++; if (bus.doutA !== 64'd15 || bus.rdyA !== 1'b1) begin bad++; $display("FAIL wr_mem got=%0d/%b exp=15/1", bus.doutA, bus.rdyA); end
  endtask

  task automatic test_load_busy();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd9; bus.Ra = 5'd9;
    #1;
    total++; if (bus.ld_issue_ack !== 1'b1) begin bad++; $display("FAIL issue_ack got=%b exp=1", bus.ld_issue_ack); end
    step();
    bus.Ra = 5'd9;
    #1;
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL issue_cnt got=%0d exp=1", bus.busy_cnt); end
    total++; if (bus.rdyA !== 1'b0 || bus.doutA !== 64'd15) begin bad++; $display("FAIL issue_rdy got=%b/%0d exp=0/15", bus.rdyA, bus.doutA); end
    bus.WE_Reg = 1'b1; bus.Rw = 5'd9; bus.dIN = 64'd77;
    #1;
    total++; if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL busy_wr_ack got=%b exp=0", bus.wr_ack); end
    total++; if (bus.doutA !== 64'd15) begin bad++; $display("FAIL busy_no_bypass got=%0d exp=15", bus.doutA); end
    step();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd9; bus.Ra = 5'd9;
    #1;
    total++; if (bus.ld_issue_ack !== 1'b0) begin bad++; $display("FAIL dup_issue_ack got=%b exp=0", bus.ld_issue_ack); end
    total++; if (bus.doutA !== 64'd15) begin bad++; $display("FAIL busy_mem_kept got=%0d exp=15", bus.doutA); end
    step();
    #1;
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL dup_cnt got=%0d exp=1", bus.busy_cnt); end
  endtask

  task automatic test_load_return();
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd9; bus.ld_ret_data = 64'd50; bus.Ra = 5'd9; bus.Rb = 5'd9;
    #1;
    total++; if (bus.doutA !== 64'd50 || bus.rdyA !== 1'b1) begin bad++; $display("FAIL ret_bypass got=%0d/%b exp=50/1", bus.doutA, bus.rdyA); end
    total++; if (bus.doutB !== 64'd50 || bus.rdyB !== 1'b1) begin bad++; $display("FAIL ret_bypassB got=%0d/%b exp=50/1", bus.doutB, bus.rdyB); end
    step();
    bus.Ra = 5'd9;
    #1;
    total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL ret_cnt got=%0d exp=0", bus.busy_cnt); end
    total++; if (bus.doutA !== 64'd50 || bus.rdyA !== 1'b1) begin bad++; $display("FAIL ret_mem got=%0d/%b exp=50/1", bus.doutA, bus.rdyA); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ret_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_ret_issue_same();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd3;
    step();
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd3; bus.ld_ret_data = 64'hAA;
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd3; bus.Ra = 5'd3;
    #1;
    total++; if (bus.ld_issue_ack !== 1'b1) begin bad++; $display("FAIL reissue_ack got=%b exp=1", bus.ld_issue_ack); end
    total++; if (bus.doutA !== 64'hAA || bus.rdyA !== 1'b1) begin bad++; $display("FAIL reissue_bypass got=%0h/%b exp=aa/1", bus.doutA, bus.rdyA); end
    step();
    bus.Ra = 5'd3;
    #1;
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL reissue_cnt got=%0d exp=1", bus.busy_cnt); end
    total++; if (bus.doutA !== 64'hAA || bus.rdyA !== 1'b0) begin bad++; $display("FAIL reissue_mem got=%0h/%b exp=aa/0", bus.doutA, bus.rdyA); end
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd3; bus.ld_ret_data = 64'hBB;
    step();
    #1;
    total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL reissue_drain got=%0d exp=0", bus.busy_cnt); end
  endtask

  task automatic test_alu_issue_same();
    bus.WE_Reg = 1'b1; bus.Rw = 5'd7; bus.dIN = 64'h70; bus.ld_issue = 1'b1; bus.ld_rd = 5'd7;
    #1;
    total++; if (bus.wr_ack !== 1'b1 || bus.ld_issue_ack !== 1'b1) begin bad++; $display("FAIL alu_issue_acks got=%b%b exp=11", bus.wr_ack, bus.ld_issue_ack); end
    step();
    bus.Rb = 5'd7;
    #1;
    total++; if (bus.doutB !== 64'h70 || bus.rdyB !== 1'b0) begin bad++; $display("FAIL alu_issue_mem got=%0h/%b exp=70/0", bus.doutB, bus.rdyB); end
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL alu_issue_cnt got=%0d exp=1", bus.busy_cnt); end
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd7; bus.ld_ret_data = 64'h71;
    step();
  endtask

  task automatic test_zero_reg();
    bus.WE_Reg = 1'b1; bus.Rw = 5'd0; bus.dIN = 64'hFF;
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd0; bus.ld_ret_data = 64'hEE;
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd0; bus.Ra = 5'd0;
    #1;
    total++; if (bus.doutA !== 64'd0 || bus.rdyA !== 1'b1) begin bad++; $display("FAIL zero_bypass got=%0h/%b exp=0/1", bus.doutA, bus.rdyA); end
    total++; if (bus.ld_issue_ack !== 1'b1 || bus.wr_ack !== 1'b1) begin bad++; $display("FAIL zero_acks got=%b%b exp=11", bus.ld_issue_ack, bus.wr_ack); end
    step();
    #1;
    total++; if (bus.doutA !== 64'd0) begin bad++; $display("FAIL zero_mem got=%0h exp=0", bus.doutA); end
    total++; if (bus.busy_cnt !== 6'd0 || bus.err !== 1'b0) begin bad++; $display("FAIL zero_state got=%0d/%b exp=0/0", bus.busy_cnt, bus.err); end
  endtask

  task automatic test_reset_midflight();
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd5;
    step();
    #1;
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL mid_cnt got=%0d exp=1", bus.busy_cnt); end
    #2 rst_n = 1'b0;
    bus.Ra = 5'd5; bus.Rb = 5'd9;
    #1;
    total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", bus.busy_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.Ra = 5'd5; bus.Rb = 5'd9;
    #1;
    total++; if (bus.rdyA !== 1'b1 || bus.doutB !== 64'd0) begin bad++; $display("FAIL mid_rst_clear got=%b/%0h exp=1/0", bus.rdyA, bus.doutB); end
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd5; bus.ld_ret_data = 64'h55;
    #1;
    total++; if (bus.doutA !== 64'h55) begin bad++; $display("FAIL mid_ret_bypass got=%0h exp=55", bus.doutA); end
    step();
    bus.Ra = 5'd5;
    #1;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL mid_err got=%b exp=1", bus.err); end
    total++; if (bus.doutA !== 64'h55 || bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_mem got=%0h/%0d exp=55/0", bus.doutA, bus.busy_cnt); end
  endtask

  task automatic test_alu_ret_same();
    bus.WE_Reg = 1'b1; bus.Rw = 5'd6; bus.dIN = 64'h1;
    bus.ld_ret = 1'b1; bus.ld_ret_rd = 5'd6; bus.ld_ret_data = 64'h2; bus.Ra = 5'd6;
    #1;
    total++; if (bus.wr_ack !== 1'b1 || bus.doutA !== 64'h2) begin bad++; $display("FAIL alu_ret_bypass got=%b/%0h exp=1/2", bus.wr_ack, bus.doutA); end
    step();
    bus.Ra = 5'd6;
    #1;
    total++; if (bus.doutA !== 64'h2 || bus.err !== 1'b1) begin bad++; $display("FAIL alu_ret_mem got=%0h/%b exp=2/1", bus.doutA, bus.err); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_write();
    test_load_busy();
    test_load_return();
    test_ret_issue_same();
    test_alu_issue_same();
    test_zero_reg();
    test_reset_midflight();
    test_alu_ret_same();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised successor to the two-read/one-write register bank in the LoadStore datapath. Adds a load scoreboard: a busy bit per register marks outstanding memory loads, read ports report readiness, and a dedicated load-return write port lands memory data. Register 0 is hard-wired to zero, and both write ports bypass to the read ports in the same cycle. It sits between the decode/issue logic, which stalls on rdyA/rdyB/acks, and the data-memory return path.

## Interface
Parameters:
- DATA_W, 64, register width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Ra  in  ADDR_W  read address A
- Rb  in  ADDR_W  read address B
- doutA  out  DATA_W  read data A (combinational)
- doutB  out  DATA_W  read data B (combinational)
- rdyA  out  1  data on doutA is valid (not awaiting load)
- rdyB  out  1  data on doutB is valid
- Rw  in  ADDR_W  ALU write address
- WE_Reg  in  1  ALU write request
- dIN  in  DATA_W  ALU write data
- wr_ack  out  1  ALU write accepted this cycle
- ld_issue  in  1  a load to ld_rd is being issued
- ld_rd  in  ADDR_W  load destination
- ld_issue_ack  out  1  load issue accepted
- ld_ret  in  1  load data returning
- ld_ret_rd  in  ADDR_W  returning destination
- ld_ret_data  in  DATA_W  returning data
- busy_cnt  out  ADDR_W+1  number of outstanding loads
- err  out  1  sticky: load returned to a non-busy register

## Operation
- Storage: NUM_REGS x DATA_W; register 0 always reads 0, and writes to it are discarded. busy[0] is never set.
- clr = ld_ret & busy[ld_ret_rd] & (ld_ret_rd != 0).
- wr_ack = WE_Reg & (Rw == 0 | ~busy[Rw]). A rejected write leaves all state unchanged; the requester holds and retries.
- ld_issue_ack = ld_issue & (ld_rd == 0 | ~busy[ld_rd] | (clr & ld_ret_rd == ld_rd)). Only one load may be outstanding per register.
- Accepted ALU write: mem[Rw] <= dIN.
- ld_ret: mem[ld_ret_rd] <= ld_ret_data and busy[ld_ret_rd] <= 0, even if the register is not busy. In that not-busy case, err <= 1 and busy_cnt is unchanged.
- Accepted issue (ld_rd != 0): busy[ld_rd] <= 1.
- Same-register events in one cycle:
  - ALU write plus accepted issue: data written and busy set, because the ALU instruction is older.
  - ld_ret plus issue: data written and busy remains 1.
  - ALU write and ld_ret to the same busy register cannot both succeed, because wr_ack = 0.
  - ALU write and ld_ret to the same non-busy register: ld_ret data wins (and err is set).
- Read port X, priority order:
  - addr == 0 -> 0, rdy = 1.
  - ld_ret & ld_ret_rd == addr -> ld_ret_data, rdy = 1.
  - wr_ack & Rw == addr -> dIN, rdy = 1.
  - Otherwise -> mem[addr], rdy = ~busy[addr].
- busy_cnt next value = busy_cnt + (accepted issue, rd != 0) - clr. It cannot exceed NUM_REGS-1, and it never underflows.

## Timing
- Reads and bypass are combinational, with zero latency. All acks are combinational from the current inputs and state.
- All state updates on the rising edge of clk. A written value is visible from mem the cycle after the write and via bypass in the write cycle.
- Reset (asynchronous, any time, including with loads outstanding):
  - All mem = 0, busy = 0, busy_cnt = 0, err = 0.
  - Outputs in reset: doutA = doutB = 0, rdyA = rdyB = 1.
  - Loads that return after reset set err.
- err clears only on reset.

## Structure
- Package reg_bank_pkg holds DATA_W and ADDR_W defaults, the NUM_REGS constant and the register-0 constant.
- Sub-module reg_scoreboard holds the busy vector, busy_cnt, err and the ack/clr logic. reg_bank_sb holds storage, write muxing and the read/bypass paths.

## Test plan
- Reset, then WE_Reg=1, Rw=9, dIN=15 -> wr_ack=1, and doutA=15 in the same cycle (Ra=9). After the edge, Ra=9 gives doutA=15, rdyA=1.
- ld_issue with ld_rd=9 -> ack, busy_cnt=1, rdyA=0 (Ra=9). A WE_Reg to Rw=9 then gets wr_ack=0 and mem is unchanged. A second issue to 9 gets ld_issue_ack=0.
- ld_ret with ld_ret_rd=9, data=50 -> same-cycle doutA=50, rdyA=1. Next cycle busy_cnt=0 and mem[9]=50.
- Same cycle: ld_ret to 3 and ld_issue to 3 (3 busy) -> ack=1, mem[3] written, busy[3] still 1, busy_cnt unchanged.
- Writes to register 0 from both ports and an issue to 0 -> doutA=0 for Ra=0, busy_cnt=0, err=0.
- Issue to 5, then assert rst_n=0 mid-flight, then ld_ret to 5 -> after reset busy_cnt=0; after the return err=1 and mem[5] holds the returned data.
